// File: rtl/delay_pipe.sv
// Stallable multi-tap delay line with per-sample valid tags and a run-time
// selectable delay; busy tracks the settle window after a delay change.
module delay_pipe #(
  parameter int WIDTH   = 38,
  parameter int MAX_DEL = 4,
  parameter int DEL_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [DEL_W-1:0] del_sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [DEL_W-1:0] del_cur,
  output logic             busy
);

  localparam logic [0:0]       RUN     = 1'b0;
  localparam logic [0:0]       SETTLE  = 1'b1;
  localparam logic [DEL_W-1:0] MAX_SEL = DEL_W'(MAX_DEL);

  logic [WIDTH-1:0] stageData_q [1:MAX_DEL];
  logic [WIDTH-1:0] stageData_d [1:MAX_DEL];
  logic [MAX_DEL:1] stageValid_q;
  logic [MAX_DEL:1] stageValid_d;
  logic [DEL_W-1:0] delCur_q;
  logic [DEL_W-1:0] delCur_d;
  logic [DEL_W-1:0] settleCnt_q;
  logic [DEL_W-1:0] settleCnt_d;
  logic [0:0]       state_q;
  logic [0:0]       state_d;

  logic [DEL_W-1:0] delReq;
  logic             delChange;
  logic             clearTags;

  // Out-of-range requests saturate to the deepest tap.
  always_comb begin
    delReq    = (del_sel > MAX_SEL) ? MAX_SEL : del_sel;
    delChange = (delReq != delCur_q);
    clearTags = flush | delChange;
  end

  // A delay change invalidates everything in flight so no stale sample
  // can appear valid at the new tap.
  always_comb begin
    stageData_d  = stageData_q;
    stageValid_d = stageValid_q;
    if (en) begin
      stageData_d[1]  = din;
      stageValid_d[1] = din_valid;
      for (int i = 2; i <= MAX_DEL; i++) begin
        stageData_d[i]  = stageData_q[i-1];
        stageValid_d[i] = stageValid_q[i-1];
      end
    end
    if (clearTags) begin
      stageValid_d = '0;
    end
  end

  always_comb begin
    delCur_d    = delCur_q;
    settleCnt_d = settleCnt_q;
    state_d     = state_q;
    if (delChange) begin
      delCur_d    = delReq;
      settleCnt_d = delReq;
      state_d     = (delReq != '0) ? SETTLE : RUN;
    end else if ((state_q == SETTLE) && en && (settleCnt_q != '0)) begin
      settleCnt_d = settleCnt_q - DEL_W'(1);
      if (settleCnt_q == DEL_W'(1)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= MAX_DEL; i++) begin
        stageData_q[i] <= '0;
      end
      stageValid_q <= '0;
      delCur_q     <= '0;
      settleCnt_q  <= '0;
      state_q      <= RUN;
    end else begin
      for (int i = 1; i <= MAX_DEL; i++) begin
        stageData_q[i] <= stageData_d[i];
      end
      stageValid_q <= stageValid_d;
      delCur_q     <= delCur_d;
      settleCnt_q  <= settleCnt_d;
      state_q      <= state_d;
    end
  end

  // A zero delay bypasses the storage entirely.
  always_comb begin
    dout       = din;
    dout_valid = din_valid;
    for (int i = 1; i <= MAX_DEL; i++) begin
      if (delCur_q == DEL_W'(i)) begin
        dout       = stageData_q[i];
        dout_valid = stageValid_q[i];
      end
    end
  end

  assign del_cur = delCur_q;
  assign busy    = (state_q == SETTLE);

endmodule

// File: tb/tb_delay_pipe.sv
// Self-checking bench for delay_pipe: directed scenarios followed by random
// traffic, compared against a sample-history reference model.
module tb_delay_pipe;

  localparam int WIDTH   = 38;
  localparam int MAX_DEL = 4;
  localparam int DEL_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic [DEL_W-1:0] del_sel;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [DEL_W-1:0] del_cur;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Reference model: every enabled sample since reset is recorded in order;
  // a clear marks all samples recorded so far (including the one entering
  // on that edge) as never-valid.
  logic [WIDTH-1:0] histData[$];
  bit               histValid[$];
  int               enCount;
  int               firstValid;
  int               delCurM;
  int               busyLeft;

  delay_pipe #(.WIDTH(WIDTH), .MAX_DEL(MAX_DEL), .DEL_W(DEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .del_sel(del_sel),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
    .del_cur(del_cur), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    logic [WIDTH-1:0] expData;
    logic             expValid;
    int               n;
    if (delCurM == 0) begin
      expData  = din;
      expValid = din_valid;
    end else begin
      n = enCount - delCurM;
      if (n < 0) begin
        expData  = '0;
        expValid = 1'b0;
      end else begin
        expData  = histData[n];
        expValid = histValid[n] && (n >= firstValid);
      end
    end
    checks++;
    assert (dout === expData) else begin
      errors++;
      $error("[TB] FAIL dout: observed=%h expected=%h", dout, expData);
    end
    checks++;
    assert (dout_valid === expValid) else begin
      errors++;
      $error("[TB] FAIL dout_valid: observed=%b expected=%b", dout_valid, expValid);
    end
    checks++;
    assert (del_cur === DEL_W'(delCurM)) else begin
      errors++;
      $error("[TB] FAIL del_cur: observed=%0d expected=%0d", del_cur, delCurM);
    end
    checks++;
    assert (busy === (busyLeft > 0)) else begin
      errors++;
      $error("[TB] FAIL busy: observed=%b expected=%b", busy, busyLeft > 0);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic f,
                               input int s, input logic [WIDTH-1:0] d,
                               input logic dv);
    int  req;
    bit  change;
    rst_n     = r;
    en        = e;
    flush     = f;
    del_sel   = DEL_W'(s);
    din       = d;
    din_valid = dv;
    @(posedge clk);
    if (!r) begin
      histData.delete();
      histValid.delete();
      enCount    = 0;
      firstValid = 0;
      delCurM    = 0;
      busyLeft   = 0;
    end else begin
      req    = (s > MAX_DEL) ? MAX_DEL : s;
      change = (req != delCurM);
      if (e) begin
        histData.push_back(d);
        histValid.push_back(dv);
        enCount++;
      end
      if (f || change) firstValid = enCount;
      if (change) begin
        delCurM  = req;
        busyLeft = req;
      end else if (e && busyLeft > 0) begin
        busyLeft--;
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [63:0] rnd;
    int          sel;
    logic [WIDTH-1:0] word;

    enCount = 0; firstValid = 0; delCurM = 0; busyLeft = 0;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; del_sel = '0; din = '0; din_valid = 1'b0;
    @(negedge clk);

    // Reset, then settle at delay 3 and stream an incrementing count.
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 38'h0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3, 38'h0, 1'b0);
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3, 38'(i), 1'b1);

    // Delay 2 with en toggling every cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2, 38'h0, 1'b0);
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, (i % 2) == 0, 1'b0, 2, 38'hA0 + 38'(i), 1'b1);

    // Delay 4 with a full valid pipe, one flush cycle, then more data.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4, 38'h100 + 38'(i), 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4, 38'h1FF, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4, 38'h200 + 38'(i), 1'b1);

    // Shrink to delay 1, then drop to passthrough.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1, 38'h300 + 38'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0, 38'h310 + 38'(i), 1'b1);

    // Out-of-range select saturates; re-change while still settling.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 7, 38'h400 + 38'(i), 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2, 38'h410 + 38'(i), 1'b1);

    // Reset mid-stream overrides flush, en and the delay request.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3, 38'h500 + 38'(i), 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3, 38'h5FF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 38'h600, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 38'h601, 1'b0);

    // Random traffic with occasional delay changes, flushes and resets.
    sel = 2;
    for (int i = 0; i < 600; i++) begin
      rnd  = {$urandom(), $urandom()};
      word = rnd[WIDTH-1:0];
      if ($urandom_range(0, 15) == 0) sel = $urandom_range(0, 7);
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, sel, word, $urandom_range(0, 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
